// File: rtl/memory_responder.sv
// memory_responder: memory-side responder for the CPU rd_mem/wr_mem strobes.
// After every reset it zero-fills the internal word array (INIT). It then
// services one access at a time against that array. Each access takes
// WAIT_CYCLES wait states and ends with a one-cycle mem_ready pulse.
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous active-low reset
//   rd_mem     - read request strobe
//   wr_mem     - write request strobe
//   adr        - word address
//   data_in    - write data
//   data_out   - registered read data, held between reads
//   mem_ready  - one-cycle completion pulse (high while in DONE)
//   busy       - access in flight or INIT running
//   init_done  - zero-fill finished
//   err        - one-cycle pulse for a rejected request
module memory_responder #(
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_mem,
   input  logic              wr_mem,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              mem_ready,
   output logic              busy,
   output logic              init_done,
   output logic              err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned CMP_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADR  = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic              NO_WAIT   = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [ADDR_W-1:0]   init_ptr, init_ptr_nxt;

   logic [ADDR_W-1:0]   lat_adr;
   logic [DATA_W-1:0]   lat_data;
   logic                lat_wr;

   logic [DATA_W-1:0]   mem [DEPTH];

   // request classification, only meaningful in IDLE/DONE
   logic req_sel, in_range, req_ok, req_bad, init_last;

   // output-comb results
   logic                complete;
   logic                cmp_wr;
   logic [ADDR_W-1:0]   cmp_adr;
   logic [DATA_W-1:0]   cmp_data;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wadr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                rd_en;
   logic                busy_nxt, err_nxt, init_done_nxt;

   assign req_sel   = (state == S_IDLE) || (state == S_DONE);
   assign in_range  = (CMP_W'(adr) < CMP_W'(DEPTH));
   assign req_ok    = req_sel && (rd_mem ^ wr_mem) && in_range;
   assign req_bad   = req_sel && ((rd_mem && wr_mem) || ((rd_mem || wr_mem) && !in_range));
   assign init_last = (init_ptr == LAST_ADR);

   // State register, including the init pointer and wait counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_INIT;
         cnt      <= '0;
         init_ptr <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         init_ptr <= init_ptr_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      init_ptr_nxt = init_ptr;
      case (state)
         S_INIT: begin
            init_ptr_nxt = init_ptr + ADDR_W'(1);
            if (init_last) state_nxt = S_IDLE;
         end
         S_IDLE, S_DONE: begin
            if (req_ok) begin
               state_nxt = NO_WAIT ? S_DONE : S_WAIT;
               cnt_nxt   = WAIT_LOAD;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = S_DONE;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // Output logic: every entry into DONE is a completion. With zero wait
   // states the completing access is the one on the inputs right now.
   always_comb begin
      complete      = (state_nxt == S_DONE);
      cmp_wr        = wr_mem;
      cmp_adr       = adr;
      cmp_data      = data_in;
      mem_we        = 1'b0;
      mem_wadr      = cmp_adr;
      mem_wdata     = cmp_data;
      rd_en         = 1'b0;
      busy_nxt      = 1'b1;
      err_nxt       = 1'b0;
      init_done_nxt = init_done;

      if (state == S_WAIT) begin
         cmp_wr   = lat_wr;
         cmp_adr  = lat_adr;
         cmp_data = lat_data;
      end

      case (state)
         S_INIT: begin
            mem_we        = 1'b1;
            mem_wadr      = init_ptr;
            mem_wdata     = '0;
            busy_nxt      = !init_last;
            init_done_nxt = init_last;
         end
         S_IDLE, S_DONE: begin
            busy_nxt = req_ok;
            err_nxt  = req_bad;
         end
         default: busy_nxt = 1'b1;
      endcase

      if (state != S_INIT) begin
         mem_we    = complete && cmp_wr;
         mem_wadr  = cmp_adr;
         mem_wdata = cmp_data;
         rd_en     = complete && !cmp_wr;
      end
   end

   // Registered outputs and request latches
   always_ff @(posedge clk) begin
      if (!reset) begin
         data_out  <= '0;
         mem_ready <= 1'b0;
         busy      <= 1'b1;
         init_done <= 1'b0;
         err       <= 1'b0;
         lat_adr   <= '0;
         lat_data  <= '0;
         lat_wr    <= 1'b0;
      end else begin
         mem_ready <= complete;
         busy      <= busy_nxt;
         init_done <= init_done_nxt;
         err       <= err_nxt;
         if (rd_en) data_out <= mem[cmp_adr];
         if (req_ok) begin
            lat_adr  <= adr;
            lat_data <= data_in;
            lat_wr   <= wr_mem;
         end
      end
   end

   // Word array; writes are suppressed while reset is asserted
   always_ff @(posedge clk) begin
      if (reset && mem_we) mem[mem_wadr] <= mem_wdata;
   end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder using three instances:
//   u0: DEPTH=32, WAIT_CYCLES=1   u1: DEPTH=20, WAIT_CYCLES=0
//   u2: DEPTH=32, WAIT_CYCLES=3
module tb_memory_responder;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst  [3];
   logic       rd   [3];
   logic       wr   [3];
   logic [4:0] adr  [3];
   logic [7:0] din  [3];
   logic [7:0] dout [3];
   logic       rdy  [3];
   logic       bsy  [3];
   logic       idn  [3];
   logic       er   [3];

   int errors = 0;
   int checks = 0;

   memory_responder #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .WAIT_CYCLES(1)) u0 (
      .clk(clk), .reset(rst[0]), .rd_mem(rd[0]), .wr_mem(wr[0]), .adr(adr[0]),
      .data_in(din[0]), .data_out(dout[0]), .mem_ready(rdy[0]), .busy(bsy[0]),
      .init_done(idn[0]), .err(er[0]));

   memory_responder #(.ADDR_W(5), .DATA_W(8), .DEPTH(20), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .reset(rst[1]), .rd_mem(rd[1]), .wr_mem(wr[1]), .adr(adr[1]),
      .data_in(din[1]), .data_out(dout[1]), .mem_ready(rdy[1]), .busy(bsy[1]),
      .init_done(idn[1]), .err(er[1]));

   memory_responder #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .WAIT_CYCLES(3)) u2 (
      .clk(clk), .reset(rst[2]), .rd_mem(rd[2]), .wr_mem(wr[2]), .adr(adr[2]),
      .data_in(din[2]), .data_out(dout[2]), .mem_ready(rdy[2]), .busy(bsy[2]),
      .init_done(idn[2]), .err(er[2]));

   // one rising edge, then settle so outputs show the post-edge state
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // single-wait-state read on u0: request edge, then DONE edge
   task automatic read0(input logic [4:0] a);
      rd[0] = 1'b1; adr[0] = a;
      step();
      rd[0] = 1'b0;
      step();
   endtask

   initial begin
      logic any_rdy;
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; adr[i] = '0; din[i] = '0;
      end

      // reset held for two edges
      step(); step();
      chk1("rst_busy",      bsy[0], 1'b1);
      chk1("rst_init_done", idn[0], 1'b0);
      chk8("rst_data_out",  dout[0], 8'h00);
      chk1("rst_ready",     rdy[0], 1'b0);
      chk1("rst_err",       er[0],  1'b0);

      // release; strobes during INIT must be ignored
      for (int i = 0; i < 3; i++) rst[i] = 1'b1;
      rd[0] = 1'b1; adr[0] = 5'd3;
      rd[1] = 1'b1; wr[1] = 1'b1; adr[1] = 5'd1;
      for (int n = 1; n <= 32; n++) begin
         step();
         if (n == 10) begin
            chk1("init_ignore_err0",   er[0],  1'b0);
            chk1("init_ignore_rdy0",   rdy[0], 1'b0);
            chk1("init_ignore_err1",   er[1],  1'b0);
            rd[0] = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0;
         end
         if (n == 19) chk1("u1_init_done_early", idn[1], 1'b0);
         if (n == 20) chk1("u1_init_done",       idn[1], 1'b1);
         if (n == 31) chk1("u0_init_done_early", idn[0], 1'b0);
         if (n == 32) begin
            chk1("u0_init_done", idn[0], 1'b1);
            chk1("u0_init_busy", bsy[0], 1'b0);
            chk1("u2_init_done", idn[2], 1'b1);
         end
      end

      // u0: write 0xA5 to 5 then read it back
      wr[0] = 1'b1; adr[0] = 5'd5; din[0] = 8'hA5;
      step();
      chk1("wr_wait_busy", bsy[0], 1'b1);
      chk1("wr_wait_rdy",  rdy[0], 1'b0);
      wr[0] = 1'b0;
      step();
      chk1("wr_done_rdy",  rdy[0], 1'b1);
      chk8("wr_done_dout", dout[0], 8'h00);
      rd[0] = 1'b1; adr[0] = 5'd5;
      step();
      chk1("rd_wait_rdy",  rdy[0], 1'b0);
      chk1("rd_wait_busy", bsy[0], 1'b1);
      rd[0] = 1'b0;
      step();
      chk1("rd_done_rdy",  rdy[0], 1'b1);
      chk8("rd_done_dout", dout[0], 8'hA5);
      step();
      chk1("idle_rdy",  rdy[0], 1'b0);
      chk1("idle_busy", bsy[0], 1'b0);

      // u0: other addresses were zero-filled
      read0(5'd31);
      chk1("rd31_rdy",  rdy[0], 1'b1);
      chk8("rd31_dout", dout[0], 8'h00);
      read0(5'd5);
      chk8("rd5_again", dout[0], 8'hA5);
      step();

      // u0: conflicting strobes
      rd[0] = 1'b1; wr[0] = 1'b1; adr[0] = 5'd7; din[0] = 8'h3C;
      step();
      chk1("conf_err",  er[0],  1'b1);
      chk1("conf_rdy",  rdy[0], 1'b0);
      chk1("conf_busy", bsy[0], 1'b0);
      rd[0] = 1'b0; wr[0] = 1'b0;
      step();
      chk1("conf_err_end", er[0],  1'b0);
      chk1("conf_rdy_end", rdy[0], 1'b0);
      read0(5'd7);
      chk1("conf_rd7_rdy",  rdy[0], 1'b1);
      chk8("conf_rd7_dout", dout[0], 8'h00);

      // u1: zero wait states, back-to-back
      wr[1] = 1'b1; adr[1] = 5'd3; din[1] = 8'h5A;
      step();
      chk1("u1_wr_rdy",  rdy[1], 1'b1);
      chk8("u1_wr_dout", dout[1], 8'h00);
      wr[1] = 1'b0; rd[1] = 1'b1;
      step();
      chk1("b2b_rdy1",  rdy[1], 1'b1);
      chk8("b2b_dout",  dout[1], 8'h5A);
      chk1("b2b_busy1", bsy[1], 1'b1);
      step();
      chk1("b2b_rdy2",  rdy[1], 1'b1);
      chk1("b2b_busy2", bsy[1], 1'b1);
      step();
      chk1("b2b_rdy3",  rdy[1], 1'b1);
      chk1("b2b_busy3", bsy[1], 1'b1);
      rd[1] = 1'b0;
      step();
      chk1("b2b_rdy_end",  rdy[1], 1'b0);
      chk1("b2b_busy_end", bsy[1], 1'b0);

      // u1: out of range with DEPTH=20
      rd[1] = 1'b1; adr[1] = 5'd25;
      step();
      chk1("oor25_err", er[1],  1'b1);
      chk1("oor25_rdy", rdy[1], 1'b0);
      adr[1] = 5'd20;
      step();
      chk1("oor20_err", er[1], 1'b1);
      adr[1] = 5'd19;
      step();
      chk1("in19_err",  er[1],  1'b0);
      chk1("in19_rdy",  rdy[1], 1'b1);
      chk8("in19_dout", dout[1], 8'h00);
      rd[1] = 1'b0;
      step();
      chk1("in19_rdy_end", rdy[1], 1'b0);

      // u2: three wait states -> ready after the fourth edge
      wr[2] = 1'b1; adr[2] = 5'd9; din[2] = 8'h77;
      step();
      wr[2] = 1'b0;
      step(); step();
      chk1("w3_rdy_early", rdy[2], 1'b0);
      step();
      chk1("w3_rdy", rdy[2], 1'b1);
      step();

      // u2: reset during WAIT of a write
      wr[2] = 1'b1; adr[2] = 5'd2; din[2] = 8'hFF;
      step();
      chk1("mid_busy", bsy[2], 1'b1);
      wr[2] = 1'b0;
      step();
      rst[2] = 1'b0;
      step();
      chk1("mid_rst_rdy",  rdy[2], 1'b0);
      chk1("mid_rst_busy", bsy[2], 1'b1);
      chk1("mid_rst_idn",  idn[2], 1'b0);
      rst[2] = 1'b1;
      any_rdy = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         step();
         any_rdy = any_rdy | rdy[2];
      end
      chk1("mid_no_ready", any_rdy, 1'b0);
      chk1("mid_reinit",   idn[2],  1'b1);
      rd[2] = 1'b1; adr[2] = 5'd2;
      step();
      rd[2] = 1'b0;
      step(); step();
      chk1("mid_rd_early", rdy[2], 1'b0);
      step();
      chk1("mid_rd_rdy",  rdy[2], 1'b1);
      chk8("mid_rd_dout", dout[2], 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
